// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer:
// FSM states, decoder flag layout, instruction class masks and trap causes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_BR   = 2'd0,
        CLS_ALUI = 2'd1,
        CLS_ALUR = 2'd2
    } iclass_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_MISALIGN = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_t;

    localparam int FLAG_W = 23;

    // Flag bit positions as driven by instruction_decoder
    localparam int F_AND  = 0;
    localparam int F_OR   = 1;
    localparam int F_XOR  = 2;
    localparam int F_SLTU = 3;
    localparam int F_SLT  = 4;
    localparam int F_SLL  = 5;
    localparam int F_SUB  = 6;
    localparam int F_ADD  = 7;
    localparam int F_SRAI = 8;
    localparam int F_SRLI = 9;
    localparam int F_SLLI = 10;
    localparam int F_ANDI = 11;
    localparam int F_ORI  = 12;
    localparam int F_XORI = 13;
    localparam int F_SLTIU = 14;
    localparam int F_SLTI = 15;
    localparam int F_ADDI = 16;
    localparam int F_BEQ  = 17;
    localparam int F_BGE  = 18;
    localparam int F_BGEU = 19;
    localparam int F_BLT  = 20;
    localparam int F_BLTU = 21;
    localparam int F_BNE  = 22;

    localparam logic [FLAG_W-1:0] BR_MASK   = 23'h7E_0000;
    localparam logic [FLAG_W-1:0] ALUI_MASK = 23'h01_FF00;
    localparam logic [FLAG_W-1:0] ALUR_MASK = 23'h00_00FF;

    function automatic logic is_onehot(input logic [FLAG_W-1:0] f);
        return (f != '0) && ((f & (f - 23'd1)) == '0);
    endfunction

endpackage

// File: rtl/inst_class.sv
// Combinational classifier for the decoder's one-hot flags; flags_bad marks
// an all-zero or multi-hot vector.
module inst_class
    import ctrl_pkg::*;
(
    input  logic [FLAG_W-1:0] inst_flags,
    output logic              is_branch,
    output logic              is_alu_imm,
    output logic              is_alu_reg,
    output logic              flags_bad
);

    assign is_branch  = |(inst_flags & BR_MASK);
    assign is_alu_imm = |(inst_flags & ALUI_MASK);
    assign is_alu_reg = |(inst_flags & ALUR_MASK);
    assign flags_bad  = !is_onehot(inst_flags);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer and PC owner for the RV32I core.
// Define MULTICYCLE_CTRL_PERF_EN to add the instret/stall_cnt counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic              dec_en,
    input  logic [FLAG_W-1:0] inst_flags,
    input  logic              invalid_instruction,
    input  logic              br_taken,
    input  logic [31:0]       br_imm,
    output logic              alu_en,
    output logic              rf_we,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              trap,
    output logic [1:0]        trap_cause
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]       instret,
    output logic [31:0]       stall_cnt
`endif
);

    // Timeout fires on the last allowed non-ack cycle, before the counter wraps
    localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state, state_nxt;
    iclass_t     cls_q, cls_nxt;
    logic [31:0] pc_nxt, ir_nxt, br_target, pc_inc;
    logic [7:0]  wait_cnt, wait_nxt;
    logic        trap_nxt;
    logic [1:0]  cause_nxt;
    logic        is_branch, is_alu_imm, is_alu_reg, flags_bad;
    logic        br_misalign;

    inst_class u_cls (
        .inst_flags (inst_flags),
        .is_branch  (is_branch),
        .is_alu_imm (is_alu_imm),
        .is_alu_reg (is_alu_reg),
        .flags_bad  (flags_bad)
    );

    assign br_target   = pc + br_imm;
    assign pc_inc      = pc + 32'd4;
    assign br_misalign = br_taken && (br_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cls_q      <= CLS_BR;
            pc         <= RESET_PC;
            ir         <= '0;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            state      <= state_nxt;
            cls_q      <= cls_nxt;
            pc         <= pc_nxt;
            ir         <= ir_nxt;
            wait_cnt   <= wait_nxt;
            trap       <= trap_nxt;
            trap_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cls_nxt   = cls_q;
        pc_nxt    = pc;
        ir_nxt    = ir;
        wait_nxt  = wait_cnt;
        trap_nxt  = trap;
        cause_nxt = trap_cause;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    wait_nxt  = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_DECODE;
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt = S_TRAP;
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_TIMEOUT;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                if (invalid_instruction || flags_bad) begin
                    state_nxt = S_TRAP;
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                    if (is_branch)       cls_nxt = CLS_BR;
                    else if (is_alu_imm) cls_nxt = CLS_ALUI;
                    else if (is_alu_reg) cls_nxt = CLS_ALUR;
                end
            end
            S_EXEC: begin
                if (cls_q != CLS_BR) begin
                    state_nxt = S_WB;
                end else if (br_misalign) begin
                    state_nxt = S_TRAP;
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_MISALIGN;
                end else begin
                    pc_nxt    = br_taken ? br_target : pc_inc;
                    state_nxt = halt_req ? S_IDLE : S_FETCH;
                    wait_nxt  = '0;
                end
            end
            S_WB: begin
                pc_nxt    = pc_inc;
                state_nxt = halt_req ? S_IDLE : S_FETCH;
                wait_nxt  = '0;
            end
            S_TRAP: begin
                if (start) begin
                    trap_nxt  = 1'b0;
                    cause_nxt = CAUSE_NONE;
                    state_nxt = S_FETCH;
                    wait_nxt  = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // All outputs decode from registered state only
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dec_en    = (state == S_DECODE) || (state == S_EXEC);
    assign alu_en    = (state == S_EXEC) && (cls_q != CLS_BR);
    assign rf_we     = (state == S_WB);
    assign busy      = (state != S_IDLE) && (state != S_TRAP);

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;
    assign retire = (state == S_WB) ||
                    ((state == S_EXEC) && (cls_q == CLS_BR) && !br_misalign);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret   <= '0;
            stall_cnt <= '0;
        end else begin
            if (retire)
                instret <= instret + 32'd1;
            if ((state == S_FETCH) && !imem_ack)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed literal checks followed by random
// traffic, all cycles compared against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_WB = 4, P_TRAP = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, imem_ack = 1'b0;
    logic        invalid_instruction = 1'b0, br_taken = 1'b0;
    logic [31:0] imem_rdata = '0, br_imm = '0;
    logic [22:0] inst_flags = '0;
    logic        imem_req, dec_en, alu_en, rf_we, busy, trap;
    logic [31:0] imem_addr, ir, pc;
    logic [1:0]  trap_cause;

    int checks = 0, errors = 0;
    int busy_cycles = 0;
    bit rf_we_seen = 0;

    // reference model state
    int          ph = P_IDLE;
    int          m_waits = 0;
    bit          model_ok = 0, m_br = 0, m_trap = 0;
    logic [31:0] m_pc = '0, m_ir = '0;
    logic [1:0]  m_cause = '0;

    multicycle_ctrl #(.RESET_PC(32'h0), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .dec_en(dec_en),
        .inst_flags(inst_flags), .invalid_instruction(invalid_instruction),
        .br_taken(br_taken), .br_imm(br_imm), .alu_en(alu_en), .rf_we(rf_we),
        .pc(pc), .busy(busy), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model advanced on each rising edge
    initial forever begin
        logic [31:0] tgt;
        @(posedge clk);
        if (!rst_n) begin
            ph = P_IDLE; m_pc = 32'h0; m_ir = '0; m_trap = 0; m_cause = 2'b00;
            m_waits = 0; model_ok = 1;
        end else if (model_ok) begin
            case (ph)
                P_IDLE: if (start) begin ph = P_FETCH; m_waits = 0; end
                P_FETCH: begin
                    if (imem_ack) begin
                        m_ir = imem_rdata; ph = P_DEC;
                    end else begin
                        m_waits++;
                        if (m_waits == TO) begin ph = P_TRAP; m_trap = 1; m_cause = 2'b11; end
                    end
                end
                P_DEC: begin
                    if (invalid_instruction || $countones(inst_flags) != 1) begin
                        ph = P_TRAP; m_trap = 1; m_cause = 2'b01;
                    end else begin
                        m_br = (inst_flags[22:17] != 6'd0);
                        ph = P_EXEC;
                    end
                end
                P_EXEC: begin
                    if (!m_br) ph = P_WB;
                    else begin
                        tgt = m_pc + br_imm;
                        if (br_taken && tgt[1:0] != 2'b00) begin
                            ph = P_TRAP; m_trap = 1; m_cause = 2'b10;
                        end else begin
                            m_pc = br_taken ? tgt : m_pc + 32'd4;
                            ph = halt_req ? P_IDLE : P_FETCH; m_waits = 0;
                        end
                    end
                end
                P_WB: begin
                    m_pc = m_pc + 32'd4; ph = halt_req ? P_IDLE : P_FETCH; m_waits = 0;
                end
                default: if (start) begin m_trap = 0; m_cause = 2'b00; ph = P_FETCH; m_waits = 0; end
            endcase
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk1("imem_req", imem_req, ph == P_FETCH);
            chk("imem_addr", imem_addr, m_pc);
            chk("ir", ir, m_ir);
            chk1("dec_en", dec_en, ph == P_DEC || ph == P_EXEC);
            chk1("alu_en", alu_en, ph == P_EXEC && !m_br);
            chk1("rf_we", rf_we, ph == P_WB);
            chk("pc", pc, m_pc);
            chk1("busy", busy, ph != P_IDLE && ph != P_TRAP);
            chk1("trap", trap, m_trap);
            chk("trap_cause", 32'(trap_cause), 32'(m_cause));
            if (busy) busy_cycles++;
            if (rf_we) rf_we_seen = 1;
        end
    end

    // Start from IDLE/TRAP, zero-wait fetch, run one instruction with halt
    task automatic run_inst(input logic [22:0] fl, input logic inv, input logic tk,
                            input logic [31:0] imm);
        busy_cycles = 0; rf_we_seen = 0;
        start = 1; cyc(); start = 0;
        imem_ack = 1; imem_rdata = $urandom; cyc(); imem_ack = 0;
        inst_flags = fl; invalid_instruction = inv; br_taken = tk; br_imm = imm; halt_req = 1;
        cyc(); cyc(); cyc();
        halt_req = 0; invalid_instruction = 0; br_taken = 0; inst_flags = '0;
    endtask

    localparam logic [22:0] FL_ADDI = 23'h01_0000;
    localparam logic [22:0] FL_BEQ  = 23'h02_0000;
    localparam logic [22:0] FL_BNE  = 23'h40_0000;
    localparam logic [22:0] FL_AND  = 23'h00_0001;

    initial begin
        // reset
        rst_n = 0; cyc(); cyc();
        chk("rst_pc", pc, 32'h0); chk1("rst_busy", busy, 0); chk1("rst_req", imem_req, 0);
        chk1("rst_trap", trap, 0); chk("rst_ir", ir, 32'h0); chk("rst_cause", 32'(trap_cause), 0);
        chk1("rst_dec", dec_en, 0); chk1("rst_alu", alu_en, 0); chk1("rst_we", rf_we, 0);
        rst_n = 1; cyc();

        // addi, zero-wait fetch, stepped cycle by cycle
        start = 1; cyc(); start = 0;
        chk1("addi_f_req", imem_req, 1); chk("addi_f_addr", imem_addr, 32'h0);
        imem_ack = 1; imem_rdata = 32'h0050_0093; cyc(); imem_ack = 0;
        chk1("addi_d_dec", dec_en, 1); chk("addi_d_ir", ir, 32'h0050_0093);
        inst_flags = FL_ADDI; cyc();
        chk1("addi_e_alu", alu_en, 1); chk1("addi_e_we", rf_we, 0);
        halt_req = 1; cyc();
        chk1("addi_wb_we", rf_we, 1); chk("addi_wb_pc", pc, 32'h0);
        cyc(); halt_req = 0; inst_flags = '0;
        chk("addi_pc", pc, 32'h4); chk1("addi_idle", busy, 0);

        // three not-taken branches walk pc to 0x10, then beq back by 8
        for (int i = 0; i < 3; i++) run_inst(FL_BEQ, 0, 0, 32'h0);
        chk("bnt_pc", pc, 32'h10);
        run_inst(FL_BEQ, 0, 1, 32'hFFFF_FFF8);
        chk("beq_pc", pc, 32'h8); chk("beq_cpi", 32'(busy_cycles), 32'd3);
        chk1("beq_no_we", rf_we_seen, 0);

        // misaligned branch target
        run_inst(FL_BNE, 0, 1, 32'h6);
        chk1("mis_trap", trap, 1); chk("mis_cause", 32'(trap_cause), 32'h2); chk("mis_pc", pc, 32'h8);
        cyc(); chk("mis_pc_frozen", pc, 32'h8);
        start = 1; cyc(); start = 0;
        chk1("restart_trap", trap, 0); chk1("restart_req", imem_req, 1); chk("restart_addr", imem_addr, 32'h8);
        imem_ack = 1; cyc(); imem_ack = 0;
        inst_flags = FL_ADDI; halt_req = 1; cyc(); cyc(); cyc(); halt_req = 0; inst_flags = '0;
        chk("restart_pc", pc, 32'hC);

        // fetch timeout, then ack on the final allowed cycle
        start = 1; cyc(); start = 0;
        cyc(); cyc(); cyc();
        chk1("to_c4_req", imem_req, 1); chk1("to_c4_trap", trap, 0);
        cyc();
        chk1("to_trap", trap, 1); chk("to_cause", 32'(trap_cause), 32'h3); chk1("to_req_low", imem_req, 0);
        start = 1; cyc(); start = 0;
        cyc(); cyc(); cyc();
        imem_ack = 1; cyc(); imem_ack = 0;
        chk1("ack_last_trap", trap, 0); chk1("ack_last_dec", dec_en, 1);
        inst_flags = FL_ADDI; halt_req = 1; cyc(); cyc(); cyc(); halt_req = 0; inst_flags = '0;
        chk("ack_last_pc", pc, 32'h10);

        // illegal decodes
        run_inst(23'h00_0003, 0, 0, 32'h0);
        chk1("multi_trap", trap, 1); chk("multi_cause", 32'(trap_cause), 32'h1); chk("multi_pc", pc, 32'h10);
        run_inst(FL_ADDI, 1, 0, 32'h0);
        chk("inv_cause", 32'(trap_cause), 32'h1); chk("inv_cpi", 32'(busy_cycles), 32'd2);
        run_inst(23'h0, 0, 0, 32'h0);
        chk("zero_cause", 32'(trap_cause), 32'h1);

        // PC wrap at top of address space
        run_inst(FL_BEQ, 0, 1, 32'hFFFF_FFEC);
        chk("wrap_setup_pc", pc, 32'hFFFF_FFFC); chk1("wrap_setup_trap", trap, 0);
        run_inst(FL_AND, 0, 0, 32'h0);
        chk("wrap_pc", pc, 32'h0); chk1("wrap_busy", busy, 0);
        chk("alu_cpi", 32'(busy_cycles), 32'd4); chk1("alu_we", rf_we_seen, 1);

        // reset in the middle of a fetch, late ack ignored
        run_inst(FL_ADDI, 0, 0, 32'h0);
        start = 1; cyc(); start = 0;
        chk1("mid_req", imem_req, 1);
        rst_n = 0; cyc(); rst_n = 1;
        chk1("mid_rst_req", imem_req, 0); chk("mid_rst_pc", pc, 32'h0); chk1("mid_rst_busy", busy, 0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; cyc(); imem_ack = 0;
        chk1("late_ack_busy", busy, 0); chk("late_ack_ir", ir, 32'h0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 2) == 0);
            halt_req   = ($urandom_range(0, 3) == 0);
            imem_ack   = ($urandom_range(0, 1) == 0);
            imem_rdata = $urandom;
            invalid_instruction = ($urandom_range(0, 15) == 0);
            br_taken   = $urandom_range(0, 1) != 0;
            br_imm     = $urandom;
            if ($urandom_range(0, 3) != 0) br_imm[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) inst_flags = 23'($urandom);
            else if ($urandom_range(0, 1) == 0) inst_flags = 23'(1) << $urandom_range(17, 22);
            else inst_flags = 23'(1) << $urandom_range(0, 16);
            cyc();
        end
        rst_n = 0; start = 0; imem_ack = 0; cyc(); rst_n = 1; cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
